// File: rtl/irq_timer.sv
// irq_timer: memory-mapped reload timer with interrupt and free-running SYSTICK.
// Registers (exact byte-address match against BASE_ADDR):
//   +0x00 TH      reload value loaded into TL on overflow
//   +0x04 TL      up-counter, counts while TCON[0]=1
//   +0x08 TCON    [0] count enable, [1] interrupt enable, [2] status (sticky)
//   +0x14 SYSTICK free-running cycle counter, read-only
// Bus handshake: there is no valid/ready pair; MemWrite qualifies a single-edge
// store, and MemRead qualifies a purely combinational load with no side effects.
module irq_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h40000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        Kernel,
    output logic [31:0] ReadData,
    output logic        IRQ
);

    localparam logic [31:0] TH_ADDR      = BASE_ADDR + 32'h0000_0000;
    localparam logic [31:0] TL_ADDR      = BASE_ADDR + 32'h0000_0004;
    localparam logic [31:0] TCON_ADDR    = BASE_ADDR + 32'h0000_0008;
    localparam logic [31:0] SYSTICK_ADDR = BASE_ADDR + 32'h0000_0014;

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [31:0] systick_q, systick_d;

    logic sel_th, sel_tl, sel_tcon, sel_systick;
    logic wr_th, wr_tl, wr_tcon;
    logic overflow;
    logic status_set;

    // Address decode and write strobes.
    always_comb begin
        sel_th      = (Address == TH_ADDR);
        sel_tl      = (Address == TL_ADDR);
        sel_tcon    = (Address == TCON_ADDR);
        sel_systick = (Address == SYSTICK_ADDR);
        wr_th       = MemWrite & sel_th;
        wr_tl       = MemWrite & sel_tl;
        wr_tcon     = MemWrite & sel_tcon;
        overflow    = tcon_q[0] & (tl_q == 32'hFFFF_FFFF);
        // A CPU store to TL on the overflow edge cancels the overflow's effects.
        status_set  = overflow & tcon_q[1] & ~wr_tl;
    end

    // Next-state: CPU writes win over counting; status set beats a software clear.
    always_comb begin
        th_d      = th_q;
        tl_d      = tl_q;
        tcon_d    = tcon_q;
        systick_d = systick_q + 32'd1;

        if (wr_th) begin
            th_d = WriteData;
        end

        if (wr_tl) begin
            tl_d = WriteData;
        end else if (tcon_q[0]) begin
            // Reload uses the pre-edge TH even if TH is written on this edge.
            tl_d = overflow ? th_q : tl_q + 32'd1;
        end

        if (wr_tcon) begin
            tcon_d = WriteData[2:0];
        end
        if (status_set) begin
            tcon_d[2] = 1'b1;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q      <= 32'h0;
            tl_q      <= 32'h0;
            tcon_q    <= 3'b000;
            systick_q <= 32'h0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            systick_q <= systick_d;
        end
    end

    // Combinational load data; zero when not reading a mapped register.
    always_comb begin
        ReadData = 32'h0;
        if (MemRead) begin
            if (sel_th) begin
                ReadData = th_q;
            end else if (sel_tl) begin
                ReadData = tl_q;
            end else if (sel_tcon) begin
                ReadData = {29'h0, tcon_q};
            end else if (sel_systick) begin
                ReadData = systick_q;
            end
        end
    end

    // Interrupt request, masked while the CPU runs in kernel mode.
    always_comb begin
        IRQ = tcon_q[1] & tcon_q[2] & ~Kernel;
    end

endmodule

// File: tb/tb_irq_timer.sv
// Testbench for irq_timer: directed scenarios with literal expectations plus
// randomized bus traffic checked every cycle against a register-level model.
module tb_irq_timer;

    localparam logic [31:0] BASE = 32'h40000000;
    localparam logic [31:0] A_TH = BASE + 32'h0;
    localparam logic [31:0] A_TL = BASE + 32'h4;
    localparam logic [31:0] A_TC = BASE + 32'h8;
    localparam logic [31:0] A_UN = BASE + 32'hC;
    localparam logic [31:0] A_ST = BASE + 32'h14;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Address = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic        Kernel = 1'b0;
    logic [31:0] ReadData;
    logic        IRQ;

    int checks = 0;
    int failures = 0;

    irq_timer #(.BASE_ADDR(BASE)) dut (
        .clk(clk),
        .reset(reset),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .Address(Address),
        .WriteData(WriteData),
        .Kernel(Kernel),
        .ReadData(ReadData),
        .IRQ(IRQ)
    );

    // ---------------- clock / reset ----------------
    always #10 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_th = 0, m_tl = 0, m_systick = 0;
    logic [2:0]  m_tcon = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_th = 0; m_tl = 0; m_tcon = 0; m_systick = 0;
        end else begin
            logic        enabled, wraps, w_th, w_tl, w_tc;
            logic [31:0] old_th;
            enabled = m_tcon[0];
            wraps   = enabled && (m_tl == 32'hFFFFFFFF);
            w_th    = MemWrite && (Address == A_TH);
            w_tl    = MemWrite && (Address == A_TL);
            w_tc    = MemWrite && (Address == A_TC);
            old_th  = m_th;
            m_systick = m_systick + 1;
            if (w_th) m_th = WriteData;
            if (w_tl) m_tl = WriteData;
            else if (wraps) m_tl = old_th;
            else if (enabled) m_tl = m_tl + 1;
            if (wraps && !w_tl && m_tcon[1]) begin
                m_tcon = w_tc ? (WriteData[2:0] | 3'b100) : (m_tcon | 3'b100);
            end else if (w_tc) begin
                m_tcon = WriteData[2:0];
            end
        end
    end

    function automatic logic [31:0] model_read();
        if (!MemRead) return 32'h0;
        case (Address)
            A_TH:    return m_th;
            A_TL:    return m_tl;
            A_TC:    return {29'h0, m_tcon};
            A_ST:    return m_systick;
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare away from the active edge.
    always @(negedge clk) begin
        chk("cyc_readdata", ReadData, model_read());
        chk("cyc_irq", {31'h0, IRQ}, {31'h0, m_tcon[1] & m_tcon[2] & ~Kernel});
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1; Address = a; WriteData = d;
        tick();
        MemWrite = 1'b0; Address = 32'h0; WriteData = 32'h0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        MemRead = 1'b1; Address = a;
        #1;
        chk(name, ReadData, exp);
        MemRead = 1'b0; Address = 32'h0;
    endtask

    task automatic irq_chk(input string name, input logic exp);
        #1;
        chk(name, {31'h0, IRQ}, {31'h0, exp});
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] st0;

    initial begin
        // Reset state while held.
        #1;
        irq_chk("rst_irq", 1'b0);
        rd_chk("rst_th", A_TH, 32'h0);
        rd_chk("rst_tl", A_TL, 32'h0);
        rd_chk("rst_tcon", A_TC, 32'h0);
        rd_chk("rst_systick", A_ST, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        rd_chk("first_edge_systick", A_ST, 32'h1);
        rd_chk("first_edge_tl", A_TL, 32'h0);

        // Overflow with interrupt enabled.
        wr(A_TH, 32'hFFFFFFFC);
        wr(A_TL, 32'hFFFFFFFE);
        wr(A_TC, 32'h3);
        rd_chk("ovf_tl_start", A_TL, 32'hFFFFFFFE);
        tick();
        rd_chk("ovf_tl_1", A_TL, 32'hFFFFFFFF);
        tick();
        rd_chk("ovf_tl_reload", A_TL, 32'hFFFFFFFC);
        rd_chk("ovf_tcon", A_TC, 32'h7);
        irq_chk("ovf_irq", 1'b1);

        // Kernel masking and software clear.
        Kernel = 1'b1;
        irq_chk("kernel_mask", 1'b0);
        Kernel = 1'b0;
        irq_chk("kernel_unmask", 1'b1);
        wr(A_TC, 32'h3);
        irq_chk("clear_irq", 1'b0);
        rd_chk("clear_tcon", A_TC, 32'h3);

        // TCON write on the overflow edge: status still set.
        wr(A_TL, 32'hFFFFFFFF);
        wr(A_TC, 32'h3);
        rd_chk("tcwr_ovf_tcon", A_TC, 32'h7);
        rd_chk("tcwr_ovf_tl", A_TL, 32'hFFFFFFFC);
        wr(A_TC, 32'h3);
        // TL write on the overflow edge: write wins, no status.
        wr(A_TL, 32'hFFFFFFFF);
        wr(A_TL, 32'h10);
        rd_chk("tlwr_ovf_tl", A_TL, 32'h10);
        rd_chk("tlwr_ovf_tcon", A_TC, 32'h3);

        // Overflow with interrupt disabled.
        wr(A_TC, 32'h0);
        wr(A_TH, 32'hFFFFFFFC);
        wr(A_TL, 32'hFFFFFFFE);
        wr(A_TC, 32'h1);
        tick();
        tick();
        rd_chk("noie_tl", A_TL, 32'hFFFFFFFC);
        rd_chk("noie_tcon", A_TC, 32'h1);
        irq_chk("noie_irq", 1'b0);

        // TH write on the overflow edge: reload uses the old TH.
        wr(A_TL, 32'hFFFFFFFF);
        wr(A_TH, 32'h55);
        rd_chk("thwr_ovf_tl", A_TL, 32'hFFFFFFFC);
        rd_chk("thwr_ovf_th", A_TH, 32'h55);

        // Reset mid-count with interrupt pending.
        wr(A_TC, 32'h3);
        wr(A_TL, 32'hFFFFFFFF);
        tick();
        irq_chk("pre_reset_irq", 1'b1);
        reset = 1'b1;
        irq_chk("midrst_irq", 1'b0);
        rd_chk("midrst_th", A_TH, 32'h0);
        rd_chk("midrst_tl", A_TL, 32'h0);
        rd_chk("midrst_tcon", A_TC, 32'h0);
        rd_chk("midrst_systick", A_ST, 32'h0);
        tick();
        reset = 1'b0;
        repeat (5) tick();
        rd_chk("post_rst_systick", A_ST, 32'h5);
        rd_chk("post_rst_tl", A_TL, 32'h0);

        // Unmapped read and ignored SYSTICK write.
        rd_chk("unmapped_read", A_UN, 32'h0);
        MemRead = 1'b1; Address = A_ST;
        #1;
        st0 = ReadData;
        MemRead = 1'b0;
        wr(A_ST, 32'h1234);
        rd_chk("systick_wr_ignored", A_ST, st0 + 32'h1);

        // Randomized traffic checked by the per-cycle compare.
        for (int i = 0; i < 3000; i++) begin
            MemRead  = ($urandom_range(0, 1) == 1);
            MemWrite = ($urandom_range(0, 3) == 0);
            Kernel   = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 6))
                0:       Address = A_TH;
                1, 2:    Address = A_TL;
                3, 4:    Address = A_TC;
                5:       Address = A_ST;
                default: Address = ($urandom_range(0, 1) == 1) ? A_UN : $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       WriteData = 32'hFFFFFFFF - $urandom_range(0, 6);
                1:       WriteData = $urandom_range(0, 7);
                2:       WriteData = {29'h0, 3'($urandom_range(1, 3))};
                default: WriteData = $urandom;
            endcase
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
